median_window_3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator on the producer side of the median filter datapath. Accepts one raster-order pixel per valid cycle and buffers the two previous image lines. For every fully interior pixel position it presents the complete 3x3 window, which feeds the 3-input ascending sorter network. There is no border padding: only windows lying entirely inside the image are emitted.

---
 rtl/median_window_3x3_gen.sv | 82 ++++++++
 tb/tb_median_window_3x3_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_3x3_gen.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 shift window.
// Only windows lying fully inside the image are flagged valid.
module median_window_3x3_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int COL_W  = $clog2(IMG_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sof,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_pixel,
    output logic                out_valid,
    output logic [9*DATA_W-1:0] win,
    output logic [15:0]         center_row,
    output logic [COL_W-1:0]    center_col
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    logic [DATA_W-1:0]      linebuf0 [IMG_W];
    logic [DATA_W-1:0]      linebuf1 [IMG_W];
    logic [COL_W-1:0]       col;
    logic [COL_W-1:0]       col_cur;
    logic [15:0]            row;
    logic [15:0]            row_cur;
    logic [DATA_W-1:0]      one_up;
    logic [DATA_W-1:0]      two_up;
    logic [8:0][DATA_W-1:0] w;
    logic                   win_ready;

    // sof forces the current pixel to (0,0) regardless of counter state
    assign col_cur   = sof ? '0 : col;
    assign row_cur   = sof ? '0 : row;
    assign one_up    = linebuf1[col_cur];
    assign two_up    = linebuf0[col_cur];
    assign win_ready = (row_cur >= 16'd2) && (col_cur >= COL_W'(2));
    assign win       = w;

    always_ff @(posedge clk) begin
        if (in_valid) begin
            linebuf0[col_cur] <= linebuf1[col_cur];
            linebuf1[col_cur] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col_cur == COL_LAST) begin
                col <= '0;
                row <= (row_cur == 16'hFFFF) ? row_cur : row_cur + 16'd1;
            end else begin
                col <= col_cur + COL_W'(1);
                row <= row_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w          <= '0;
            out_valid  <= 1'b0;
            center_row <= '0;
            center_col <= '0;
        end else begin
            out_valid <= in_valid && win_ready;
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    w[r*3]   <= w[r*3+1];
                    w[r*3+1] <= w[r*3+2];
                end
                w[2]       <= two_up;
                w[5]       <= one_up;
                w[8]       <= in_pixel;
                center_row <= row_cur - 16'd1;
                center_col <= col_cur - COL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_median_window_3x3_gen.sv
// Bench for median_window_3x3_gen: a 4-wide and a 640-wide instance checked
// against an image-array model, plus hand-computed window literals.
module tb_median_window_3x3_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv4 = 1'b0, sof4 = 1'b0, iv6 = 1'b0, sof6 = 1'b0;
    logic [7:0]  px4 = '0, px6 = '0;
    logic        ov4, ov6;
    logic [71:0] win4, win6;
    logic [15:0] cr4, cr6;
    logic [1:0]  cc4;
    logic [9:0]  cc6;

    int nvec = 0;
    int nfail = 0;

    typedef struct {
        logic [71:0] w;
        int          r;
        int          c;
    } rec_t;
    rec_t q4[$];
    rec_t q6[$];

    median_window_3x3_gen #(.DATA_W(8), .IMG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sof(sof4), .in_valid(iv4), .in_pixel(px4),
        .out_valid(ov4), .win(win4), .center_row(cr4), .center_col(cc4));

    median_window_3x3_gen #(.DATA_W(8), .IMG_W(640)) dut6 (
        .clk(clk), .rst_n(rst_n), .sof(sof6), .in_valid(iv6), .in_pixel(px6),
        .out_valid(ov6), .win(win6), .center_row(cr6), .center_col(cc6));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] pk(input int a, b, c, d, e, f, g, h, i);
        int v[9];
        v = '{a, b, c, d, e, f, g, h, i};
        pk = '0;
        for (int k = 0; k < 9; k++) pk[k*8 +: 8] = v[k][7:0];
    endfunction

    // Model: store each pixel at its image position (rows kept mod 3), read windows back out.
    logic [7:0]  img [2][3][640];
    int          mrow[2], mcol[2];
    logic        ev[2];
    logic [71:0] ew[2];
    int          er[2], ec[2];

    task automatic mstep(input int i, input logic v, input logic s, input logic [7:0] d);
        int r, c, wd;
        wd = (i == 0) ? 4 : 640;
        ev[i] = 1'b0;
        if (v) begin
            r = s ? 0 : mrow[i];
            c = s ? 0 : mcol[i];
            img[i][r % 3][c] = d;
            if (r >= 2 && c >= 2) begin
                ev[i] = 1'b1;
                for (int y = 0; y < 3; y++)
                    for (int x = 0; x < 3; x++)
                        ew[i][(y*3+x)*8 +: 8] = img[i][(r-2+y) % 3][c-2+x];
                er[i] = r - 1;
                ec[i] = c - 1;
            end
            mcol[i] = c + 1;
            mrow[i] = r;
            if (mcol[i] == wd) begin
                mcol[i] = 0;
                mrow[i] = r + 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mrow[i] = 0; mcol[i] = 0; ev[i] = 1'b0;
            end
        end else begin
            mstep(0, iv4, sof4, px4);
            mstep(1, iv6, sof6, px6);
        end
    end

    task automatic cmp(input int i, input logic ov, input logic [71:0] w,
                       input logic [15:0] r, input logic [15:0] c);
        rec_t rc;
        chk($sformatf("out_valid[%0d]", i), 72'(ov), 72'(ev[i]));
        if (ev[i]) begin
            chk($sformatf("win[%0d]", i), w, ew[i]);
            chk($sformatf("center_row[%0d]", i), 72'(r), 72'(er[i]));
            chk($sformatf("center_col[%0d]", i), 72'(c), 72'(ec[i]));
        end
        if (ov) begin
            rc.w = w; rc.r = int'(r); rc.c = int'(c);
            if (i == 0) q4.push_back(rc); else q6.push_back(rc);
        end
    endtask

    always @(posedge clk) begin
        #2;
        cmp(0, ov4, win4, cr4, 16'(cc4));
        cmp(1, ov6, win6, cr6, 16'(cc6));
    end

    task automatic drive4(input logic v, input logic s, input int d);
        @(posedge clk); #1;
        iv4 = v; sof4 = s; px4 = d[7:0];
    endtask

    task automatic drive6(input logic v, input logic s, input int d);
        @(posedge clk); #1;
        iv6 = v; sof6 = s; px6 = d[7:0];
    endtask

    task automatic frame4(input int start, input int n, input logic s);
        for (int k = 0; k < n; k++) drive4(1'b1, s && (k == 0), start + k);
    endtask

    task automatic idle4(input int n);
        for (int k = 0; k < n; k++) drive4(1'b0, 1'b0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 72'(ov4), 72'(0));
        chk("reset win", win4, 72'(0));
        chk("reset center", 72'({cr4, cc4}), 72'(0));
        chk("reset out_valid 640", 72'(ov6), 72'(0));
        @(negedge clk) rst_n = 1'b1;

        // Plain 4x4 frame
        q4.delete();
        frame4(1, 16, 1'b1);
        idle4(2);
        chk("f1 count", 72'(q4.size()), 72'(4));
        if (q4.size() == 4) begin
            chk("f1 win11", q4[0].w, pk(1, 2, 3, 5, 6, 7, 9, 10, 11));
            chk("f1 ctr11", 72'({q4[0].r, q4[0].c}), 72'({32'd1, 32'd1}));
            chk("f1 win16", q4[3].w, pk(6, 7, 8, 10, 11, 12, 14, 15, 16));
            chk("f1 ctr16", 72'({q4[3].r, q4[3].c}), 72'({32'd2, 32'd2}));
        end

        // Stall between pixels 11 and 12
        q4.delete();
        frame4(1, 11, 1'b1);
        idle4(3);
        frame4(12, 5, 1'b0);
        idle4(2);
        chk("stall count", 72'(q4.size()), 72'(4));
        if (q4.size() == 4) begin
            chk("stall win12", q4[1].w, pk(2, 3, 4, 6, 7, 8, 10, 11, 12));
            chk("stall ctr12", 72'({q4[1].r, q4[1].c}), 72'({32'd1, 32'd2}));
        end

        // sof on the 6th pixel restarts the frame
        q4.delete();
        frame4(1, 5, 1'b1);
        frame4(51, 12, 1'b1);
        idle4(2);
        chk("sof6 count", 72'(q4.size()), 72'(2));
        if (q4.size() == 2) begin
            chk("sof6 win", q4[0].w, pk(51, 52, 53, 55, 56, 57, 59, 60, 61));
            chk("sof6 ctr", 72'({q4[0].r, q4[0].c}), 72'({32'd1, 32'd1}));
        end

        // Asynchronous reset mid-frame, between edges
        q4.delete();
        frame4(71, 11, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0; iv4 = 1'b0; sof4 = 1'b0;
        #1;
        chk("arst out_valid", 72'(ov4), 72'(0));
        chk("arst win", win4, 72'(0));
        chk("arst center", 72'({cr4, cc4}), 72'(0));
        @(negedge clk) rst_n = 1'b1;
        q4.delete();
        frame4(1, 11, 1'b0);
        idle4(2);
        chk("arst count", 72'(q4.size()), 72'(1));
        if (q4.size() == 1)
            chk("arst win11", q4[0].w, pk(1, 2, 3, 5, 6, 7, 9, 10, 11));

        // Back-to-back frames
        q4.delete();
        frame4(101, 16, 1'b1);
        frame4(201, 16, 1'b1);
        idle4(2);
        chk("b2b count", 72'(q4.size()), 72'(8));
        if (q4.size() == 8) begin
            chk("b2b last A", q4[3].w, pk(106, 107, 108, 110, 111, 112, 114, 115, 116));
            chk("b2b first B", q4[4].w, pk(201, 202, 203, 205, 206, 207, 209, 210, 211));
        end

        // Full-width ramp, three lines
        q6.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 640; c++)
                drive6(1'b1, (r == 0) && (c == 0), c % 256);
        repeat (2) drive6(1'b0, 1'b0, 0);
        chk("ramp count", 72'(q6.size()), 72'(638));
        if (q6.size() == 638) begin
            chk("ramp first win", q6[0].w, pk(0, 1, 2, 0, 1, 2, 0, 1, 2));
            chk("ramp first ctr", 72'({q6[0].r, q6[0].c}), 72'({32'd1, 32'd1}));
            chk("ramp last win", q6[637].w, pk(125, 126, 127, 125, 126, 127, 125, 126, 127));
            chk("ramp last col", 72'(q6[637].c), 72'(638));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
